// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: ALU opcodes, the arbiter FSM states and
// the default operand width.
package alu_arb_pkg;

    localparam int DW_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_MUL    = 3'b010,
        OP_DIVREM = 3'b011,
        OP_SHR    = 3'b100,
        OP_SHL    = 3'b101,
        OP_AND    = 3'b110,
        OP_OR     = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin selector: the first asserted request at or after the slot
// following the previous winner wins. Purely combinational.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_valid
);

    // Scan NUM_REQ slots starting after last_grant, wrapping at NUM_REQ
    always_comb begin
        logic [IW-1:0] idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters. A request is
// accepted in IDLE, its operands drive the ALU for one EXEC cycle, and the
// captured result is held in RESP until the consumer takes it.
// Optional feature: define ALU_ARB_DIVZERO_FLAG_EN to flag DIVREM with b == 0
// on rsp_err; otherwise rsp_err is constant 0.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    parameter int  DW      = DW_DEFAULT,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    input  logic [NUM_REQ*3-1:0] req_op,
    output logic [DW-1:0]        alu_a,
    output logic [DW-1:0]        alu_b,
    output logic [2:0]           alu_opcode,
    input  logic [2*DW-1:0]      alu_res,
    input  logic                 alu_ov,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IW-1:0]        rsp_id,
    output logic [2*DW-1:0]      rsp_res,
    output logic                 rsp_ov,
    output logic                 rsp_err
);

    state_e               state;
    logic [IW-1:0]        last_grant;
    logic [NUM_REQ-1:0]   grant;
    logic [IW-1:0]        grant_idx;
    logic                 grant_valid;
    logic [DW-1:0]        sel_a;
    logic [DW-1:0]        sel_b;
    logic [2:0]           sel_op;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req         (req_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign sel_a  = req_a[int'(grant_idx)*DW +: DW];
    assign sel_b  = req_b[int'(grant_idx)*DW +: DW];
    assign sel_op = req_op[int'(grant_idx)*3 +: 3];

    // Accept is only offered while idle, so the transfer edge is the IDLE->EXEC edge
    assign req_ready = (state == IDLE) ? grant : '0;

    // Control FSM; the ALU operand registers double as the latched request so
    // they hold their value outside EXEC instead of returning to zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_res    <= '0;
            rsp_ov     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        alu_a      <= sel_a;
                        alu_b      <= sel_b;
                        alu_opcode <= sel_op;
                        rsp_id     <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_res   <= alu_res;
                    rsp_ov    <= alu_ov;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_DIVZERO_FLAG_EN
    // Flag a divide by zero from the latched request when the result is captured
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (state == EXEC) begin
            rsp_err <= (alu_opcode == OP_DIVREM) && (alu_b == '0);
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: requesters are fed from per-requester
// queues, a reference model predicts grants and responses from the
// round-robin rule, and a monitor compares what the DUT presents.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int DW      = 32;
    localparam int IW      = $clog2(NUM_REQ);

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2:0]    op;
    } stim_t;

    typedef struct {
        int            id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2:0]    op;
        logic [2*DW-1:0] res;
        logic          ov;
        logic          err;
        int            due;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_a;
    logic [NUM_REQ*DW-1:0] req_b;
    logic [NUM_REQ*3-1:0]  req_op;
    logic [DW-1:0]         alu_a;
    logic [DW-1:0]         alu_b;
    logic [2:0]            alu_opcode;
    logic [2*DW-1:0]       alu_res;
    logic                  alu_ov;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [2*DW-1:0]       rsp_res;
    logic                  rsp_ov;
    logic                  rsp_err;

    stim_t stim_q [NUM_REQ][$];
    exp_t  sb[$];
    int    id_log[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    m_last = NUM_REQ - 1;
    bit    m_busy = 1'b0;
    int    m_due = 0;
    int    rsp_mode = 0;
    int    last_id = -1;
    logic [2*DW-1:0] last_res = '0;
    logic  last_ov = 1'b0;
    logic  last_err = 1'b0;

    alu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DW      (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_res    (alu_res),
        .alu_ov     (alu_ov),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_res    (rsp_res),
        .rsp_ov     (rsp_ov),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: {ov, result}
    function automatic logic [2*DW:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [2*DW-1:0] r;
        logic [DW:0]     s;
        logic            ov;
        r = '0; s = '0; ov = 1'b0;
        case (op)
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r[DW-1:0] = s[DW-1:0]; ov = s[DW]; end
            3'b001: begin s = {1'b0, a} - {1'b0, b}; r[DW-1:0] = s[DW-1:0]; ov = s[DW]; end
            3'b010: r = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
            3'b011: if (b != '0) r = {a % b, a / b};
            3'b100: r[DW-1:0] = a >> b;
            3'b101: r = {{DW{1'b0}}, a} << b;
            3'b110: r[DW-1:0] = a & b;
            default: r[DW-1:0] = a | b;
        endcase
        return {ov, r};
    endfunction

    always_comb {alu_ov, alu_res} = alu_f(alu_opcode, alu_a, alu_b);

    // Round-robin rule: first valid requester at or after (last+1) mod N
    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (last + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [2:0] op);
        stim_t s;
        s.a = a; s.b = b; s.op = op;
        stim_q[i].push_back(s);
    endtask

    function automatic bit pending();
        for (int i = 0; i < NUM_REQ; i++) if (stim_q[i].size() > 0) return 1'b1;
        return (sb.size() > 0) || m_busy;
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pending()) begin
            checks++;
            errors++;
            $display("FAIL %s drain timeout: still busy after %0d cycles", name, budget);
        end
    endtask

    // Cycle counter and reset effect on the reference model
    always @(posedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_busy = 1'b0;
            m_last = NUM_REQ - 1;
        end
        cyc++;
    end

    // Requester drivers: present the queue head, retire it once accepted
    initial begin
        logic [NUM_REQ-1:0] acc;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready & {NUM_REQ{rst_n}};
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
                if (stim_q[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_a[i*DW +: DW]   = stim_q[i][0].a;
                    req_b[i*DW +: DW]   = stim_q[i][0].b;
                    req_op[i*3 +: 3]    = stim_q[i][0].op;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Consumer: always ready, random, or stalled
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rsp_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Reference model: predicts grants and pushes expected responses
    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_ready;
        int g;
        exp_t e;
        exp_ready = '0;
        g = -1;
        if (rst_n) begin
            if (!m_busy) g = rr_pick(req_valid, m_last);
            if (g >= 0) exp_ready = NUM_REQ'(1) << g;
            check("req_ready", 128'(req_ready), 128'(exp_ready));
            if (g >= 0) begin
                e.id  = g;
                e.a   = req_a[g*DW +: DW];
                e.b   = req_b[g*DW +: DW];
                e.op  = req_op[g*3 +: 3];
                {e.ov, e.res} = alu_f(e.op, e.a, e.b);
`ifdef ALU_ARB_DIVZERO_FLAG_EN
                e.err = (e.op == 3'b011) && (e.b == '0);
`else
                e.err = 1'b0;
`endif
                e.due = cyc + 2;
                sb.push_back(e);
                m_last = g;
                m_busy = 1'b1;
                m_due  = cyc + 2;
            end else if (m_busy && cyc >= m_due && rsp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    // Monitor: compares the ALU drive and the response against the scoreboard head
    always @(negedge clk) begin
        logic exp_v;
        exp_v = (sb.size() > 0) && (cyc >= sb[0].due);
        check("rsp_valid", 128'(rsp_valid), 128'(exp_v));
        if (sb.size() > 0 && cyc == sb[0].due - 1) begin
            check("alu_a", 128'(alu_a), 128'(sb[0].a));
            check("alu_b", 128'(alu_b), 128'(sb[0].b));
            check("alu_opcode", 128'(alu_opcode), 128'(sb[0].op));
        end
        if (exp_v) begin
            check("rsp_id", 128'(rsp_id), 128'(sb[0].id));
            check("rsp_res", 128'(rsp_res), 128'(sb[0].res));
            check("rsp_ov", 128'(rsp_ov), 128'(sb[0].ov));
            check("rsp_err", 128'(rsp_err), 128'(sb[0].err));
            if (rsp_ready) begin
                last_id  = int'(rsp_id);
                last_res = rsp_res;
                last_ov  = rsp_ov;
                last_err = rsp_err;
                id_log.push_back(int'(rsp_id));
                void'(sb.pop_front());
            end
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #400000;
        checks++;
        errors++;
        $display("FAIL global timeout at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int n;
        logic exp_err;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rsp_valid", 128'(rsp_valid), 128'(0));
        check("reset rsp_res", 128'(rsp_res), 128'(0));
        check("reset rsp_ov", 128'(rsp_ov), 128'(0));
        check("reset rsp_err", 128'(rsp_err), 128'(0));
        check("reset alu_a", 128'(alu_a), 128'(0));
        check("reset alu_b", 128'(alu_b), 128'(0));
        check("reset alu_opcode", 128'(alu_opcode), 128'(0));
        check("reset req_ready", 128'(req_ready), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single ADD from requester 0
        push(0, 32'd5, 32'd7, OP_ADD);
        drain("add", 50);
        check("add id", 128'(last_id), 128'(0));
        check("add res", 128'(last_res), 128'(12));

        // Full-width multiply
        push(0, 32'hFFFF_FFFF, 32'd2, OP_MUL);
        drain("mul", 50);
        check("mul res", 128'(last_res), 128'(64'h1_FFFF_FFFE));
        check("mul ov", 128'(last_ov), 128'(0));

        // Divide by zero
        push(1, 32'd9, 32'd0, OP_DIVREM);
        drain("divzero", 50);
`ifdef ALU_ARB_DIVZERO_FLAG_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check("divzero err", 128'(last_err), 128'(exp_err));
        check("divzero res", 128'(last_res), 128'(0));
        check("divzero id", 128'(last_id), 128'(1));

        // Two requesters continuously valid: grants alternate starting at 0
        id_log.delete();
        for (int k = 0; k < 4; k++) begin
            push(0, 32'(100 + k), 32'(k), OP_SUB);
            push(1, 32'(k), 32'(200 + k), OP_OR);
        end
        drain("alternate", 200);
        check("alternate count", 128'(id_log.size()), 128'(8));
        for (int k = 0; k < 8 && k < id_log.size(); k++)
            check("alternate order", 128'(id_log[k]), 128'(k % 2));

        // Consumer stalls five cycles with another request waiting
        rsp_mode = 2;
        push(2, 32'h1234, 32'd4, OP_SHL);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall rsp_valid seen", 128'(rsp_valid), 128'(1));
        push(0, 32'hF0F0, 32'h0FF0, OP_AND);
        repeat (5) begin
            @(negedge clk);
            check("stall rsp_valid", 128'(rsp_valid), 128'(1));
            check("stall req_ready", 128'(req_ready), 128'(0));
        end
        rsp_mode = 0;
        drain("stall", 50);
        check("stall last id", 128'(last_id), 128'(0));

        // Reset during EXEC abandons the operation; requester 0 wins next
        push(0, 32'd3, 32'd4, OP_ADD);
        n = 0;
        @(negedge clk);
        while (!req_ready[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort accept seen", 128'(req_ready[0]), 128'(1));
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort rsp_valid", 128'(rsp_valid), 128'(0));
        check("abort alu_a", 128'(alu_a), 128'(0));
        check("abort alu_opcode", 128'(alu_opcode), 128'(0));
        id_log.delete();
        push(1, 32'd10, 32'd3, OP_DIVREM);
        push(0, 32'd8, 32'd2, OP_SHR);
        drain("after abort", 50);
        check("after abort count", 128'(id_log.size()), 128'(2));
        if (id_log.size() > 0) check("after abort first", 128'(id_log[0]), 128'(0));

        // Randomized traffic with a random consumer
        rsp_mode = 1;
        for (int k = 0; k < 60; k++) begin
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            push(int'($urandom_range(0, NUM_REQ - 1)), a, b, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        drain("random", 3000);
        rsp_mode = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the ALU; legal range 2..4.
REQ-002 Parameter DW, default 32, operand width; result width 2*DW.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a, req_b  input  NUM_REQ x DW (packed)  per-requester operands.
REQ-008 req_op  input  NUM_REQ x 3 (packed)  per-requester opcode.
REQ-009 alu_a, alu_b  output  DW  operands to the shared ALU.
REQ-010 alu_opcode  output  3  opcode to the shared ALU.
REQ-011 alu_res  input  2*DW  combinational ALU result.
REQ-012 alu_ov  input  1  combinational ALU overflow flag.
REQ-013 rsp_valid  output  1  response valid.
REQ-014 rsp_ready  input  1  response accept.
REQ-015 rsp_id  output  clog2(NUM_REQ)  index of the requester owning the response.
REQ-016 rsp_res  output  2*DW  registered result.
REQ-017 rsp_ov  output  1  registered overflow.
REQ-018 rsp_err  output  1  divide-by-zero error flag (see Configuration).

Function
REQ-019 FSM SHALL have states IDLE, EXEC, RESP.
REQ-020 In IDLE with any req_valid set, grant SHALL go to the first valid requester at or after index (last_grant+1) mod NUM_REQ (round-robin).
REQ-021 In IDLE, req_ready[g] SHALL be high combinationally for the granted g only; the transfer happens on that edge, and operands, opcode and g are latched; next state EXEC.
REQ-022 In IDLE with no req_valid set, all req_ready SHALL be low and the state SHALL remain IDLE.
REQ-023 In EXEC, alu_a/alu_b/alu_opcode SHALL drive the latched values; alu_res and alu_ov are captured on that edge; next state RESP.
REQ-024 Outside EXEC, alu_a, alu_b and alu_opcode SHALL hold their last latched values (no glitching to zero).
REQ-025 In RESP, rsp_valid SHALL be high and rsp_id/rsp_res/rsp_ov/rsp_err SHALL be stable until rsp_ready is sampled high; then the FSM SHALL go to IDLE.
REQ-026 Latency: rsp_valid SHALL rise two cycles after the accepting edge; minimum initiation interval three cycles.
REQ-027 req_ready SHALL be low in EXEC and RESP; pending requests wait with no loss.
REQ-028 last_grant SHALL update only on an accepting edge.
REQ-029 A requester whose req_valid drops before grant SHALL NOT be served; there is no queueing inside the block.

Reset
REQ-030 On rst_n low at a clock edge, the FSM SHALL go to IDLE, last_grant to NUM_REQ-1 (requester 0 wins first), and rsp_valid, rsp_res, rsp_ov, rsp_err, alu_a, alu_b and alu_opcode to 0.
REQ-031 Reset asserted in EXEC or RESP SHALL abandon the operation with no response.

Configuration
REQ-032 With macro ALU_ARB_DIVZERO_FLAG_EN defined, rsp_err SHALL be 1 when the latched opcode is 3'b011 and the latched b is 0; otherwise 0.
REQ-033 Without ALU_ARB_DIVZERO_FLAG_EN, the rsp_err port SHALL exist and be tied to 0.

Structure
REQ-034 Package alu_arb_pkg SHALL hold the opcode enum (ADD=000, SUB=001, MUL=010, DIVREM=011, SHR=100, SHL=101, AND=110, OR=111), the FSM state enum and the DW default.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector and last grant; output: one-hot grant plus index).

Verification
REQ-036 Single req0 ADD a=5 b=7 -> req_ready[0] for 1 cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_res=12.
REQ-037 req0 and req1 held valid continuously -> grants alternate 0,1,0,1 and each rsp_id matches.
REQ-038 rsp_ready held low 5 cycles in RESP -> rsp outputs stable and req_ready low throughout; release -> IDLE next cycle.
REQ-039 DIVREM a=9 b=0 with the macro defined -> rsp_err=1, rsp_res=0; without the macro -> rsp_err=0.
REQ-040 rst_n low during EXEC -> next cycle IDLE, rsp_valid=0, no response; next request granted to requester 0.
REQ-041 MUL a=32'hFFFF_FFFF b=2 -> rsp_res=64'h1_FFFF_FFFE, rsp_ov=0.
